// File: rtl/capture_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : capture_sequencer_pkg
// Description : Shared holdoff width and state encodings for the capture
//               sequencer and its neighbouring trigger/stop logic.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef HOLDOFF_WIDTH
`define HOLDOFF_WIDTH 8
`endif
`ifndef CS_IDLE
`define CS_IDLE    3'd0
`define CS_FILL    3'd1
`define CS_PRIMED  3'd2
`define CS_HOLDOFF 3'd3
`define CS_STOPPED 3'd4
`define CS_READOUT 3'd5
`endif

package capture_sequencer_pkg;

    localparam int C_HOLDOFF_WIDTH = `HOLDOFF_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE    = `CS_IDLE,
        ST_FILL    = `CS_FILL,
        ST_PRIMED  = `CS_PRIMED,
        ST_HOLDOFF = `CS_HOLDOFF,
        ST_STOPPED = `CS_STOPPED,
        ST_READOUT = `CS_READOUT
    } cs_state_t;

endpackage
`default_nettype wire

// File: rtl/capture_sequencer_holdoff_timer.sv
`default_nettype none
// ============================================================================
// Module      : holdoff_timer
// Description : Latches a post-trigger sample limit saturated to DEPTH-1 and
//               counts qualified samples until the limit is reached.
// Revision    : 1.0 - initial release
// ============================================================================
module holdoff_timer #(
    parameter int ADDR_WIDTH    = 4,
    parameter int HOLDOFF_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic                     inc,
    input  logic [HOLDOFF_WIDTH-1:0] limit,
    output logic                     done
);

    localparam int C_MAX = (2**ADDR_WIDTH) - 1;

    logic [ADDR_WIDTH-1:0] r_limit;
    logic [ADDR_WIDTH-1:0] r_count;
    logic [ADDR_WIDTH-1:0] w_sat_limit;

    // Saturating at DEPTH-1 keeps the writer from lapping the trigger sample
    assign w_sat_limit = (32'(limit) > 32'(C_MAX)) ? ADDR_WIDTH'(C_MAX)
                                                   : ADDR_WIDTH'(limit);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_limit <= '0;
            r_count <= '0;
        end else if (load) begin
            r_limit <= w_sat_limit;
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign done = (r_count == r_limit);

endmodule
`default_nettype wire

// File: rtl/capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : capture_sequencer
// Description : Logic analyzer capture controller: fill, prime, trigger,
//               holdoff, stop and oldest-first readout of the sample RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module capture_sequencer
    import capture_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH    = 4,
    parameter int HOLDOFF_WIDTH = C_HOLDOFF_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_arm,
    input  logic                     i_abort,
    input  logic                     i_sample_valid,
    input  logic                     i_trigger,
    input  logic [HOLDOFF_WIDTH-1:0] i_holdoff,
    input  logic                     i_rd_start,
    input  logic                     i_rd_ready,
    output logic                     o_mem_we,
    output logic [ADDR_WIDTH-1:0]    o_mem_waddr,
    output logic [ADDR_WIDTH-1:0]    o_rd_addr,
    output logic                     o_rd_valid,
    output logic                     o_rd_last,
    output logic                     o_primed,
    output logic                     o_stopped,
    output logic [ADDR_WIDTH-1:0]    o_trigger_addr,
    output logic [2:0]               o_state
);

    localparam int                    C_DEPTH     = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] C_RD_LAST   = ADDR_WIDTH'(C_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   C_FILL_LAST = (ADDR_WIDTH+1)'(C_DEPTH - 1);

    cs_state_t             r_state;
    cs_state_t             w_state;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [ADDR_WIDTH-1:0] r_rd_cnt;
    logic [ADDR_WIDTH-1:0] r_trigger_addr;
    logic [ADDR_WIDTH:0]   r_fill;
    logic                  w_we;
    logic                  w_hold_load;
    logic                  w_hold_inc;
    logic                  w_hold_done;

    // Unused encodings fold back to IDLE so the FSM always recovers
    always_comb begin
        w_state = ST_IDLE;
        case (r_state)
            ST_FILL, ST_PRIMED, ST_HOLDOFF, ST_STOPPED, ST_READOUT: w_state = r_state;
            default: w_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_we = 1'b0;
        if (!i_abort && i_sample_valid) begin
            case (w_state)
                ST_FILL, ST_PRIMED: w_we = 1'b1;
                ST_HOLDOFF:         w_we = !w_hold_done;
                default:            w_we = 1'b0;
            endcase
        end
    end

    assign w_hold_load = !i_abort && (w_state == ST_PRIMED) && i_sample_valid && i_trigger;
    assign w_hold_inc  = (w_state == ST_HOLDOFF) && w_we;

    holdoff_timer #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .HOLDOFF_WIDTH (HOLDOFF_WIDTH)
    ) u_holdoff_timer (
        .clk   (clk),
        .reset (reset),
        .load  (w_hold_load),
        .inc   (w_hold_inc),
        .limit (i_holdoff),
        .done  (w_hold_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_waddr        <= '0;
            r_rd_addr      <= '0;
            r_rd_cnt       <= '0;
            r_trigger_addr <= '0;
            r_fill         <= '0;
        end else begin
            if (w_we)
                r_waddr <= r_waddr + 1'b1;

            if (i_abort) begin
                r_state <= ST_IDLE;
            end else begin
                case (w_state)
                    ST_IDLE: begin
                        if (i_arm) begin
                            r_state <= ST_FILL;
                            r_waddr <= '0;
                            r_fill  <= '0;
                        end
                    end
                    ST_FILL: begin
                        if (w_we) begin
                            r_fill <= r_fill + 1'b1;
                            if (r_fill == C_FILL_LAST)
                                r_state <= ST_PRIMED;
                        end
                    end
                    ST_PRIMED: begin
                        if (w_hold_load) begin
                            r_trigger_addr <= r_waddr;
                            r_state        <= ST_HOLDOFF;
                        end
                    end
                    ST_HOLDOFF: begin
                        if (w_hold_done)
                            r_state <= ST_STOPPED;
                    end
                    ST_STOPPED: begin
                        if (i_arm) begin
                            r_state <= ST_FILL;
                            r_waddr <= '0;
                            r_fill  <= '0;
                        end else if (i_rd_start) begin
                            r_state   <= ST_READOUT;
                            r_rd_addr <= r_waddr;
                            r_rd_cnt  <= '0;
                        end
                    end
                    ST_READOUT: begin
                        if (i_rd_ready) begin
                            r_rd_addr <= r_rd_addr + 1'b1;
                            r_rd_cnt  <= r_rd_cnt + 1'b1;
                            if (r_rd_cnt == C_RD_LAST)
                                r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_mem_we       = w_we;
    assign o_mem_waddr    = r_waddr;
    assign o_rd_addr      = r_rd_addr;
    assign o_rd_valid     = (w_state == ST_READOUT);
    assign o_rd_last      = (w_state == ST_READOUT) && (r_rd_cnt == C_RD_LAST);
    assign o_primed       = (w_state == ST_PRIMED) || (w_state == ST_HOLDOFF);
    assign o_stopped      = (w_state == ST_STOPPED) || (w_state == ST_READOUT);
    assign o_trigger_addr = r_trigger_addr;
    assign o_state        = w_state;

endmodule
`default_nettype wire

// File: tb/tb_capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_capture_sequencer
// Description : Directed self-checking bench for capture_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_capture_sequencer;
    import capture_sequencer_pkg::*;

    localparam int AW = 4;
    localparam int HW = C_HOLDOFF_WIDTH;

    logic          clk = 1'b0;
    logic          reset;
    logic          arm, abort, sample_valid, trigger, rd_start, rd_ready;
    logic [HW-1:0] holdoff;
    logic          mem_we, rd_valid, rd_last, primed, stopped;
    logic [AW-1:0] mem_waddr, rd_addr, trigger_addr;
    logic [2:0]    state;

    int n_checks = 0;
    int n_fail   = 0;

    capture_sequencer #(.ADDR_WIDTH(AW), .HOLDOFF_WIDTH(HW)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_arm          (arm),
        .i_abort        (abort),
        .i_sample_valid (sample_valid),
        .i_trigger      (trigger),
        .i_holdoff      (holdoff),
        .i_rd_start     (rd_start),
        .i_rd_ready     (rd_ready),
        .o_mem_we       (mem_we),
        .o_mem_waddr    (mem_waddr),
        .o_rd_addr      (rd_addr),
        .o_rd_valid     (rd_valid),
        .o_rd_last      (rd_last),
        .o_primed       (primed),
        .o_stopped      (stopped),
        .o_trigger_addr (trigger_addr),
        .o_state        (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Arm, fill the whole memory, then trigger on the write to trig_at
    task automatic run_to_holdoff(input logic [HW-1:0] hold, input int trig_at);
        holdoff = hold;
        arm = 1'b1;
        step();
        arm = 1'b0;
        sample_valid = 1'b1;
        repeat (16) step();
        repeat (trig_at) step();
        trigger = 1'b1;
        step();
        trigger = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; arm = 1'b0; abort = 1'b0; sample_valid = 1'b0;
        trigger = 1'b0; rd_start = 1'b0; rd_ready = 1'b0; holdoff = '0;
        repeat (2) step();
        settle();
        check("rst_state",   state, 0);
        check("rst_we",      mem_we, 0);
        check("rst_waddr",   mem_waddr, 0);
        check("rst_flags",   {rd_valid, rd_last, primed, stopped}, 0);
        check("rst_trigadr", trigger_addr, 0);
        reset = 1'b1;
        repeat (2) step();
        check("idle_hold", state, 0);

        // Normal capture, holdoff 3, trigger at address 5
        holdoff = 3;
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("arm_fill", state, 1);
        sample_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            settle();
            check("fill_we", mem_we, 1);
            check("fill_waddr", mem_waddr, i);
            check("fill_primed", primed, 0);
            step();
        end
        check("primed_state", state, 2);
        check("primed_flag", primed, 1);
        check("primed_waddr", mem_waddr, 0);
        repeat (5) step();
        trigger = 1'b1;
        settle();
        check("trig_waddr", mem_waddr, 5);
        check("trig_we", mem_we, 1);
        step();
        trigger = 1'b0;
        check("hold_state", state, 3);
        check("trig_addr", trigger_addr, 5);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("hold_we", mem_we, 1);
            check("hold_waddr", mem_waddr, 6 + i);
            step();
        end
        settle();
        check("hold_done_we", mem_we, 0);
        step();
        check("stop_state", state, 4);
        check("stop_flag", {primed, stopped}, 2'b01);
        check("stop_waddr", mem_waddr, 9);
        check("stop_we", mem_we, 0);
        sample_valid = 1'b0;
        rd_start = 1'b1;
        rd_ready = 1'b1;
        step();
        rd_start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            settle();
            check("rd_valid", rd_valid, 1);
            check("rd_addr", rd_addr, (9 + k) % 16);
            check("rd_last", rd_last, (k == 15) ? 1 : 0);
            step();
        end
        check("rd_end_state", state, 0);
        check("rd_end_valid", rd_valid, 0);

        // Holdoff 0, then backpressure and abort during readout
        run_to_holdoff(0, 5);
        settle();
        check("h0_no_write", mem_we, 0);
        step();
        check("h0_stop", state, 4);
        check("h0_waddr", mem_waddr, 6);
        sample_valid = 1'b0;
        rd_start = 1'b1;
        rd_ready = 1'b0;
        step();
        rd_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("bp_addr", rd_addr, 6);
            check("bp_valid", rd_valid, 1);
            step();
        end
        rd_ready = 1'b1;
        repeat (2) step();
        check("bp_adv", rd_addr, 8);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_state", state, 0);
        check("abort_valid", rd_valid, 0);

        // Triggers during fill are ignored, including on the final fill write
        arm = 1'b1;
        step();
        arm = 1'b0;
        sample_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            trigger = (i == 3 || i == 15);
            step();
        end
        trigger = 1'b0;
        check("fill_trig_state", state, 2);
        check("fill_trig_addr", trigger_addr, 5);

        // Oversized holdoff saturates at 15 writes
        holdoff = 100;
        repeat (5) step();
        trigger = 1'b1;
        settle();
        check("sat_trig_waddr", mem_waddr, 5);
        step();
        trigger = 1'b0;
        check("sat_hold_state", state, 3);
        for (int i = 0; i < 15; i++) begin
            settle();
            check("sat_we", mem_we, 1);
            check("sat_waddr", mem_waddr, (6 + i) % 16);
            step();
        end
        settle();
        check("sat_done_we", mem_we, 0);
        step();
        check("sat_stop", state, 4);
        check("sat_waddr_end", mem_waddr, 5);
        check("sat_trig_addr", trigger_addr, 5);
        sample_valid = 1'b0;
        rd_start = 1'b1;
        rd_ready = 1'b1;
        step();
        rd_start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            settle();
            check("sat_rd_addr", rd_addr, (5 + k) % 16);
            check("sat_rd_last", rd_last, (k == 15) ? 1 : 0);
            step();
        end
        check("sat_rd_end", state, 0);

        // Arm and read-start together in STOPPED: arm wins
        run_to_holdoff(0, 3);
        step();
        check("ar_stop", state, 4);
        sample_valid = 1'b0;
        arm = 1'b1;
        rd_start = 1'b1;
        step();
        arm = 1'b0;
        rd_start = 1'b0;
        check("ar_state", state, 1);
        check("ar_waddr", mem_waddr, 0);
        check("ar_valid", rd_valid, 0);

        // Reset asserted mid-holdoff with samples still arriving
        abort = 1'b1;
        step();
        abort = 1'b0;
        run_to_holdoff(8, 2);
        step();
        settle();
        check("mr_pre_we", mem_we, 1);
        check("mr_pre_state", state, 3);
        reset = 1'b0;
        #1;
        check("mr_we", mem_we, 0);
        check("mr_state", state, 0);
        check("mr_outs", {mem_waddr, trigger_addr, rd_addr}, 0);
        check("mr_flags", {rd_valid, rd_last, primed, stopped}, 0);
        step();
        reset = 1'b1;
        repeat (3) step();
        settle();
        check("mr_idle_hold", state, 0);
        check("mr_idle_we", mem_we, 0);
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("mr_arm", state, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
